// File: rtl/uart_rx_byte.sv
// 8N1 UART receiver, LSB first, with 3-sample mid-bit majority vote.
// Delivers each good byte as a one-cycle rx_ready strobe and flags bad stop bits on frame_err.
module uart_rx_byte #(
  parameter int BIT_CNT = 5208
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic       rx_ready,
  output logic [7:0] rx_data,
  output logic       frame_err,
  output logic       busy
);

  // state | meaning
  // IDLE  | line idle, waiting for a falling edge
  // START | timing the start bit, rejecting glitches at mid-bit
  // DATA  | shifting in 8 data bits, LSB first
  // STOP  | checking the stop bit at mid-bit
  // BREAK | stop bit was low; wait for the line to return high

  localparam int HALF = BIT_CNT / 2;
  localparam int CW   = $clog2(BIT_CNT);

  localparam logic [CW-1:0] CNT_LAST = CW'(BIT_CNT - 1);
  localparam logic [CW-1:0] SMP_0    = CW'(HALF - 1);
  localparam logic [CW-1:0] SMP_1    = CW'(HALF);
  localparam logic [CW-1:0] SMP_DEC  = CW'(HALF + 1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    DATA  = 3'd2,
    STOP  = 3'd3,
    BREAK = 3'd4
  } state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [2:0]      idx_q, idx_d;
  logic [7:0]      shift_q, shift_d;
  logic [1:0]      smp_q, smp_d;
  logic [7:0]      data_q, data_d;
  logic            ready_q, ready_d;
  logic            err_q, err_d;
  logic            rx_meta_q, rx_s_q, rx_d_q;

  logic fall;
  logic maj;
  logic decide;
  logic cnt_last;

  assign fall     = rx_d_q & ~rx_s_q;
  assign maj      = (smp_q[0] & smp_q[1]) | (smp_q[0] & rx_s_q) | (smp_q[1] & rx_s_q);
  assign decide   = (cnt_q == SMP_DEC);
  assign cnt_last = (cnt_q == CNT_LAST);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx_meta_q <= 1'b1;
      rx_s_q    <= 1'b1;
      rx_d_q    <= 1'b1;
    end else begin
      rx_meta_q <= rx;
      rx_s_q    <= rx_meta_q;
      rx_d_q    <= rx_s_q;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      shift_q <= '0;
      smp_q   <= '0;
      data_q  <= '0;
      ready_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
      smp_q   <= smp_d;
      data_q  <= data_d;
      ready_q <= ready_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    shift_d = shift_q;
    smp_d   = smp_q;
    data_d  = data_q;
    ready_d = 1'b0;
    err_d   = 1'b0;

    if (state_q != IDLE) begin
      cnt_d = cnt_last ? '0 : cnt_q + 1'b1;
    end
    if (cnt_q == SMP_0) smp_d[0] = rx_s_q;
    if (cnt_q == SMP_1) smp_d[1] = rx_s_q;

    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (fall) state_d = START;
      end
      START: begin
        if (decide && maj) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (cnt_last) begin
          state_d = DATA;
          idx_d   = '0;
        end
      end
      DATA: begin
        if (decide) shift_d[idx_q] = maj;
        if (cnt_last) begin
          if (idx_q == 3'd7) state_d = STOP;
          else               idx_d   = idx_q + 3'd1;
        end
      end
      STOP: begin
        // Leave mid stop bit so a back-to-back start edge is caught on time.
        if (decide) begin
          cnt_d = '0;
          if (maj) begin
            data_d  = shift_q;
            ready_d = 1'b1;
            state_d = IDLE;
          end else begin
            err_d   = 1'b1;
            state_d = BREAK;
          end
        end
      end
      BREAK: begin
        cnt_d = '0;
        if (rx_s_q) state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  assign rx_ready  = ready_q;
  assign rx_data   = data_q;
  assign frame_err = err_q;
  assign busy      = (state_q != IDLE);

endmodule
